mem_arbiter: RTL and testbench

Controller for the single byte-wide memory port. Shares it between instruction fetch (IF) and the load/store buffer (LSB). Sequences multi-byte loads and stores as consecutive byte accesses, assembles and sign-extends read data, and handles flush and IO back-pressure. Sits between IF/LSB and the external RAM/IO bus.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_extend.sv | 20 ++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide memory port controller:
// size encodings, FSM states, IO window defaults and requester IDs.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam logic [31:0] IO_MASK_DEFAULT = 32'hFFFF_0000;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_LSB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_extend.sv
// Combinational sign/zero extension of an assembled byte or half-word load.
module mem_extend
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (size)
            SZ_BYTE: result = {{24{sign & raw[7]}}, raw[7:0]};
            SZ_HALF: result = {{16{sign & raw[15]}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and the load/store buffer,
// sequencing multi-byte accesses over a single byte-wide RAM/IO port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter logic [31:0] IO_MASK = IO_MASK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_instr,
    input  logic        lsb_req,
    input  logic        lsb_store,
    input  logic [1:0]  lsb_size,
    input  logic        lsb_signed,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    output logic        idle,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_t      state, state_n;
    logic        last_grant, last_grant_n, owner, owner_n;
    logic [31:0] addr, addr_n, wdata, wdata_n, data, data_n;
    logic [1:0]  size_q, size_n;
    logic [2:0]  nbytes, nbytes_n, cnt, cnt_n, cnt_inc;
    logic        is_signed, signed_n;
    logic        if_done_n, lsb_done_n, mem_wr_n;
    logic [31:0] if_instr_n, lsb_rdata_n, mem_a_n;
    logic [7:0]  mem_dout_n;

    logic        grant_lsb, acc_store, acc_signed;
    logic [31:0] acc_addr, acc_wdata, wr_addr;
    logic [1:0]  acc_size, byte_idx;
    logic [31:0] assembled, extended;

    function automatic logic is_io(input logic [31:0] a);
        return (a & IO_MASK) == IO_BASE;
    endfunction

    assign idle       = (state == S_IDLE) && !if_done && !lsb_done;
    assign cnt_inc    = cnt + 3'd1;
    assign byte_idx   = 2'(cnt - 3'd1);
    assign wr_addr    = addr + {29'd0, cnt};

    assign grant_lsb  = lsb_req && (!if_req || last_grant == REQ_IF);
    assign acc_addr   = grant_lsb ? lsb_addr : if_addr;
    assign acc_size   = grant_lsb ? lsb_size : SZ_WORD;
    assign acc_store  = grant_lsb && lsb_store;
    assign acc_signed = grant_lsb && lsb_signed;
    assign acc_wdata  = grant_lsb ? lsb_wdata : '0;

    // The last byte merges straight from mem_din so data and done share an edge.
    always_comb begin
        assembled = data;
        assembled[{byte_idx, 3'b000} +: 8] = mem_din;
    end

    mem_extend u_extend (
        .raw   (assembled),
        .size  (size_q),
        .sign  (is_signed),
        .result(extended)
    );

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        owner_n      = owner;
        addr_n       = addr;
        wdata_n      = wdata;
        data_n       = data;
        size_n       = size_q;
        nbytes_n     = nbytes;
        cnt_n        = cnt;
        signed_n     = is_signed;
        if_done_n    = 1'b0;
        lsb_done_n   = 1'b0;
        if_instr_n   = if_instr;
        lsb_rdata_n  = lsb_rdata;
        mem_a_n      = mem_a;
        mem_dout_n   = mem_dout;
        mem_wr_n     = mem_wr;

        case (state)
            S_IDLE: begin
                mem_a_n    = '0;
                mem_dout_n = '0;
                mem_wr_n   = 1'b0;
                if (idle && !rob_clear && (if_req || lsb_req)) begin
                    last_grant_n = grant_lsb ? REQ_LSB : REQ_IF;
                    owner_n      = grant_lsb ? REQ_LSB : REQ_IF;
                    addr_n       = acc_addr;
                    size_n       = acc_size;
                    nbytes_n     = size_bytes(acc_size);
                    signed_n     = acc_signed;
                    wdata_n      = acc_wdata;
                    data_n       = '0;
                    cnt_n        = '0;
                    if (acc_store) begin
                        state_n = S_WRITE;
                        if (!(is_io(acc_addr) && io_buffer_full)) begin
                            mem_a_n    = acc_addr;
                            mem_dout_n = acc_wdata[7:0];
                            mem_wr_n   = 1'b1;
                            cnt_n      = 3'd1;
                        end
                    end else begin
                        state_n = S_READ;
                        mem_a_n = acc_addr;
                    end
                end
            end
            S_READ: begin
                if (rob_clear) begin
                    state_n  = S_IDLE;
                    mem_a_n  = '0;
                    mem_wr_n = 1'b0;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc < nbytes) mem_a_n = addr + {29'd0, cnt_inc};
                    if (cnt != 3'd0) data_n = assembled;
                    if (cnt == nbytes) begin
                        state_n = S_IDLE;
                        mem_a_n = '0;
                        if (owner == REQ_IF) begin
                            if_done_n  = 1'b1;
                            if_instr_n = assembled;
                        end else begin
                            lsb_done_n  = 1'b1;
                            lsb_rdata_n = extended;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (cnt == nbytes) begin
                    state_n    = S_IDLE;
                    lsb_done_n = 1'b1;
                    mem_wr_n   = 1'b0;
                    mem_a_n    = '0;
                    mem_dout_n = '0;
                end else if (is_io(wr_addr) && io_buffer_full) begin
                    mem_wr_n = 1'b0;
                end else begin
                    mem_a_n    = wr_addr;
                    mem_dout_n = wdata[{cnt[1:0], 3'b000} +: 8];
                    mem_wr_n   = 1'b1;
                    cnt_n      = cnt_inc;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= REQ_IF;
            owner      <= REQ_IF;
            addr       <= '0;
            wdata      <= '0;
            data       <= '0;
            size_q     <= '0;
            nbytes     <= '0;
            cnt        <= '0;
            is_signed  <= 1'b0;
            if_done    <= 1'b0;
            lsb_done   <= 1'b0;
            if_instr   <= '0;
            lsb_rdata  <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
        end else if (rdy) begin
            state      <= state_n;
            last_grant <= last_grant_n;
            owner      <= owner_n;
            addr       <= addr_n;
            wdata      <= wdata_n;
            data       <= data_n;
            size_q     <= size_n;
            nbytes     <= nbytes_n;
            cnt        <= cnt_n;
            is_signed  <= signed_n;
            if_done    <= if_done_n;
            lsb_done   <= lsb_done_n;
            if_instr   <= if_instr_n;
            lsb_rdata  <= lsb_rdata_n;
            mem_a      <= mem_a_n;
            mem_dout   <= mem_dout_n;
            mem_wr     <= mem_wr_n;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, multi-cycle corner
// sequences and randomized traffic against a byte-array memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, rob_clear;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_instr;
    logic        lsb_req, lsb_store, lsb_signed, lsb_done;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic        idle, io_buffer_full, mem_wr;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;

    mem_arbiter #(.IO_BASE(32'h0003_0000), .IO_MASK(32'hFFFF_0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_instr(if_instr),
        .lsb_req(lsb_req), .lsb_store(lsb_store), .lsb_size(lsb_size),
        .lsb_signed(lsb_signed), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata), .idle(idle),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // Memory model: 64 KiB aliased window, read data one cycle after mem_a.
    logic [7:0] ram [0:65535];
    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t wlog[$];
    int  overlap = 0;

    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram[mem_a[15:0]];
            if (mem_wr) begin
                ram[mem_a[15:0]] <= mem_dout;
                wlog.push_back({mem_a, mem_dout});
            end
        end
    end

    always @(negedge clk) if (if_done && lsb_done) overlap <= overlap + 1;

    int tests = 0, fails = 0;
    bit model_last_lsb = 1'b0;

    typedef struct {
        bit          st;
        logic [1:0]  sz;
        bit          sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t vecs[10];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sg);
        logic [31:0] v = '0;
        logic [31:0] t;
        for (int k = 0; k < n; k++) begin
            t = a + 32'(k);
            v = v | (32'(ram[t[15:0]]) << (8 * k));
        end
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic check_writes(input string name, input logic [31:0] a, input logic [31:0] wd, input int n);
        logic [31:0] w;
        check32({name, "_nwrites"}, 32'(wlog.size()), 32'(n));
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            w = wd >> (8 * k);
            check32({name, "_waddr"}, wlog[k].a, a + 32'(k));
            check32({name, "_wbyte"}, 32'(wlog[k].d), 32'(w[7:0]));
        end
    endtask

    // io_mode: 0 = not full, 1 = random each cycle, 2 = held full
    task automatic lsb_txn(input bit st, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int io_mode, input bit clr_after_accept,
                           output logic [31:0] rd, output int lat);
        lsb_store = st; lsb_size = sz; lsb_signed = sg; lsb_addr = a; lsb_wdata = wd;
        io_buffer_full = (io_mode == 2);
        wlog.delete();
        lsb_req = 1'b1;
        model_last_lsb = 1'b1;
        lat = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            lat++;
            if (clr_after_accept) rob_clear = 1'b1;
            if (io_mode == 1) io_buffer_full = 1'($urandom);
            if (lsb_done) break;
        end
        check32("lsb_done_seen", 32'(lsb_done), 32'd1);
        rd = lsb_rdata;
        lsb_req = 1'b0;
        io_buffer_full = 1'b0;
        @(posedge clk); #1;
        rob_clear = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, output logic [31:0] rd, output int lat);
        if_addr = a;
        if_req = 1'b1;
        model_last_lsb = 1'b0;
        lat = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            lat++;
            if (if_done) break;
        end
        check32("if_done_seen", 32'(if_done), 32'd1);
        rd = if_instr;
        if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic both_txn(input bit st, input logic [1:0] sz, input bit sg,
                            input logic [31:0] la, input logic [31:0] wd, input logic [31:0] ia);
        logic [31:0] exp_l, exp_i;
        bit first_lsb, which;
        int got = 0;
        exp_l = model_load(la, nbytes_of(sz), sg);
        exp_i = model_load(ia, 4, 1'b0);
        lsb_store = st; lsb_size = sz; lsb_signed = sg; lsb_addr = la; lsb_wdata = wd;
        if_addr = ia;
        first_lsb = !model_last_lsb;
        wlog.delete();
        lsb_req = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            io_buffer_full = 1'($urandom);
            if (if_done || lsb_done) begin
                which = lsb_done;
                if (got == 0) check32("rr_order", 32'(which), 32'(first_lsb));
                if (which) begin
                    if (!st) check32("both_lsb_rdata", lsb_rdata, exp_l);
                    lsb_req = 1'b0;
                end else begin
                    check32("both_if_instr", if_instr, exp_i);
                    if_req = 1'b0;
                end
                got++;
                if (got == 2) break;
            end
        end
        check32("both_completed", 32'(got), 32'd2);
        if (st) check_writes("both_store", la, wd, nbytes_of(sz));
        model_last_lsb = !first_lsb;
        lsb_req = 1'b0; if_req = 1'b0; io_buffer_full = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, exp;
        int lat, seen, order_cnt;
        bit exp_lsb, st, sg;
        logic [1:0] sz;
        logic [31:0] a, wd;

        for (int i = 0; i < 65536; i++) ram[i] = '0;
        ram[16'h0100] = 8'h78; ram[16'h0101] = 8'h56; ram[16'h0102] = 8'h34; ram[16'h0103] = 8'h12;
        ram[16'h0200] = 8'h80; ram[16'h0201] = 8'hF0; ram[16'h0302] = 8'h5A;
        ram[16'hFFFE] = 8'h11; ram[16'hFFFF] = 8'h22; ram[16'h0000] = 8'h33; ram[16'h0001] = 8'h44;
        for (int i = 16'h1000; i < 16'h3000; i++) ram[i] = 8'($urandom);

        vecs[0] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 6};
        vecs[1] = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_0200, 32'h0, 32'hFFFF_FF80, 3};
        vecs[2] = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_0200, 32'h0, 32'h0000_0080, 3};
        vecs[3] = '{1'b0, SZ_HALF, 1'b1, 32'h0000_0200, 32'h0, 32'hFFFF_F080, 4};
        vecs[4] = '{1'b0, SZ_HALF, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_3456, 4};
        vecs[5] = '{1'b0, SZ_WORD, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h4433_2211, 6};
        vecs[6] = '{1'b1, SZ_HALF, 1'b0, 32'h0000_0300, 32'hAABB_CCDD, 32'h0, 3};
        vecs[7] = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_0310, 32'h0000_00EE, 32'h0, 2};
        vecs[8] = '{1'b1, SZ_WORD, 1'b0, 32'h0000_0320, 32'hCAFE_F00D, 32'h0, 5};
        vecs[9] = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0320, 32'h0, 32'hCAFE_F00D, 6};

        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_store = 1'b0; lsb_size = SZ_WORD; lsb_signed = 1'b0;
        lsb_addr = 32'h200; lsb_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check32("reset_dones", {30'd0, if_done, lsb_done}, 32'd0);
        check32("reset_data", if_instr | lsb_rdata, 32'd0);
        check32("reset_bus", {15'd0, mem_wr, mem_dout, 8'd0} | mem_a, 32'd0);
        check32("reset_idle", 32'(idle), 32'd1);
        rst = 1'b0;

        // Both requesters held from reset: round-robin alternation over 4 grants.
        order_cnt = 0;
        for (int i = 0; i < 100 && order_cnt < 4; i++) begin
            @(posedge clk); #1;
            if (if_done || lsb_done) begin
                exp_lsb = !model_last_lsb;
                model_last_lsb = exp_lsb;
                check32("reset_rr_order", 32'(lsb_done), 32'(exp_lsb));
                if (lsb_done) check32("reset_rr_lsb", lsb_rdata, 32'h0000_F080);
                else check32("reset_rr_if", if_instr, 32'h1234_5678);
                order_cnt++;
            end
        end
        check32("reset_rr_count", 32'(order_cnt), 32'd4);
        if_req = 1'b0; lsb_req = 1'b0;
        @(posedge clk); #1;

        // Word load address trace.
        lsb_store = 1'b0; lsb_size = SZ_WORD; lsb_signed = 1'b0; lsb_addr = 32'h100;
        lsb_req = 1'b1; model_last_lsb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check32("trace_mem_a", mem_a, 32'h100 + 32'(k));
            check32("trace_mem_wr", 32'(mem_wr), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        check32("trace_done", 32'(lsb_done), 32'd1);
        check32("trace_rdata", lsb_rdata, 32'h1234_5678);
        lsb_req = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            lsb_txn(vecs[i].st, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wd, 0, 1'b0, rd, lat);
            check32("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].st) check_writes("vec_store", vecs[i].addr, vecs[i].wd, nbytes_of(vecs[i].sz));
            else check32("vec_rdata", rd, vecs[i].exp_rd);
        end
        check32("half_store_untouched", 32'(ram[16'h0302]), 32'h5A);

        // Flush on the third cycle of an IF word read.
        if_addr = 32'h100; if_req = 1'b1; model_last_lsb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rob_clear = 1'b1; if_req = 1'b0;
        @(posedge clk); #1;
        check32("flush_no_done", 32'(if_done), 32'd0);
        check32("flush_idle", 32'(idle), 32'd1);
        check32("flush_bus", {31'd0, mem_wr} | mem_a, 32'd0);
        rob_clear = 1'b0;
        seen = 0;
        repeat (4) begin @(posedge clk); #1; if (if_done) seen++; end
        check32("flush_no_late_done", 32'(seen), 32'd0);

        // Requests are not accepted while rob_clear is high.
        lsb_store = 1'b0; lsb_size = SZ_BYTE; lsb_addr = 32'h200; lsb_req = 1'b1; rob_clear = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check32("clear_blocks_accept", {31'd0, idle} | mem_a, 32'd1);
        end
        lsb_req = 1'b0; rob_clear = 1'b0;
        @(posedge clk); #1;

        // A committed store completes under rob_clear.
        lsb_txn(1'b1, SZ_WORD, 1'b0, 32'h400, 32'h1122_3344, 0, 1'b1, rd, lat);
        check32("clear_store_latency", 32'(lat), 32'd5);
        check_writes("clear_store", 32'h400, 32'h1122_3344, 4);

        // IO back-pressure before byte 1 of a word store.
        lsb_store = 1'b1; lsb_size = SZ_WORD; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0102_0304;
        wlog.delete(); lsb_req = 1'b1; model_last_lsb = 1'b1; lat = 0;
        @(posedge clk); #1; lat++;
        check32("io_byte0", {mem_wr, 15'd0, mem_dout, 8'd0}, {1'b1, 15'd0, 8'h04, 8'd0});
        io_buffer_full = 1'b1;
        repeat (3) begin
            @(posedge clk); #1; lat++;
            check32("io_stall_wr", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        @(posedge clk); #1; lat++;
        check32("io_resume_a", mem_a, 32'h0003_0001);
        check32("io_resume", {mem_wr, 15'd0, mem_dout, 8'd0}, {1'b1, 15'd0, 8'h03, 8'd0});
        for (int i = 0; i < 20 && !lsb_done; i++) begin @(posedge clk); #1; lat++; end
        check32("io_store_latency", 32'(lat), 32'd8);
        check_writes("io_store", 32'h0003_0000, 32'h0102_0304, 4);
        lsb_req = 1'b0;
        @(posedge clk); #1;

        // IO reads ignore io_buffer_full.
        exp = model_load(32'h0003_0000, 4, 1'b0);
        lsb_txn(1'b0, SZ_WORD, 1'b0, 32'h0003_0000, 32'h0, 2, 1'b0, rd, lat);
        check32("io_read_latency", 32'(lat), 32'd6);
        check32("io_read_data", rd, exp);

        // rdy low for 2 cycles mid-read.
        lsb_store = 1'b0; lsb_size = SZ_WORD; lsb_signed = 1'b0; lsb_addr = 32'h100;
        lsb_req = 1'b1; model_last_lsb = 1'b1; lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        rdy = 1'b0;
        repeat (2) begin
            @(posedge clk); #1; lat++;
            check32("freeze_mem_a", mem_a, 32'h101);
        end
        rdy = 1'b1;
        for (int i = 0; i < 20 && !lsb_done; i++) begin @(posedge clk); #1; lat++; end
        check32("freeze_latency", 32'(lat), 32'd8);
        check32("freeze_rdata", lsb_rdata, 32'h1234_5678);
        lsb_req = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic against the memory model.
        for (int it = 0; it < 40; it++) begin
            st = 1'($urandom);
            sz = 2'($urandom_range(0, 2));
            sg = 1'($urandom);
            a  = 32'h1000 + 32'($urandom_range(0, 32'hFEF));
            wd = $urandom;
            case ($urandom_range(0, 2))
                0: begin
                    exp = model_load(a, nbytes_of(sz), sg);
                    lsb_txn(st, sz, sg, a, wd, 1, 1'b0, rd, lat);
                    check32("rnd_lsb_latency", 32'(lat), 32'(nbytes_of(sz) + (st ? 1 : 2)));
                    if (st) check_writes("rnd_store", a, wd, nbytes_of(sz));
                    else check32("rnd_lsb_rdata", rd, exp);
                end
                1: begin
                    a = 32'h2000 + 32'($urandom_range(0, 32'hFEF));
                    exp = model_load(a, 4, 1'b0);
                    if_txn(a, rd, lat);
                    check32("rnd_if_latency", 32'(lat), 32'd6);
                    check32("rnd_if_instr", rd, exp);
                end
                default: both_txn(st, sz, sg, a, wd, 32'h2000 + 32'($urandom_range(0, 32'hFEF)));
            endcase
        end

        check32("no_overlapping_done", 32'(overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
